// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : RV32I memory stage. Issues data-memory requests, stalls upstream
//            while an access is outstanding, and fills the MEM/WB register.
// Revision : 1.0
// ============================================================================
module mem_stage #(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [WIDTH-1:0]    alu_out_i,
    input  logic [WIDTH-1:0]    rs2_data_i,
    input  logic [4:0]          rd_addr_i,
    input  logic                rf_w_en_i,
    input  logic [1:0]          wbsel_i,
    input  logic                mem_w_en_i,
    input  logic [2:0]          funct3_i,
    output logic                stall_o,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic                dmem_we,
    output logic [ADDR_LEN-1:0] dmem_addr,
    output logic [WIDTH-1:0]    dmem_wdata,
    output logic [3:0]          dmem_wstrb,
    input  logic                dmem_rsp_valid,
    input  logic [WIDTH-1:0]    dmem_rdata,
    output logic                valid_o,
    output logic [WIDTH-1:0]    wb_data_o,
    output logic [4:0]          rd_addr_o,
    output logic                rf_w_en_o,
    output logic                misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                w_mem_op;
    logic                w_misaligned;
    logic                w_issue;
    logic [ADDR_LEN-1:0] w_pc_plus4;
    logic [WIDTH-1:0]    w_alu_wb;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [WIDTH-1:0]    w_load_data;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic             rf_w_en_q, rf_w_en_d;
    logic             misalign_q, misalign_d;

    assign w_mem_op = valid_i & ((wbsel_i == 2'd1) | mem_w_en_i);

    always_comb begin
        w_misaligned = 1'b0;
        case (funct3_i[1:0])
            2'b01:   w_misaligned = alu_out_i[0];
            2'b10:   w_misaligned = (alu_out_i[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_issue = (state_q == S_IDLE) & w_mem_op & ~w_misaligned;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_issue) state_d = dmem_req_ready ? S_WAIT : S_REQ;
            S_REQ:   if (dmem_req_ready) state_d = S_WAIT;
            S_WAIT:  if (dmem_rsp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Gated by reset so the handshake outputs are quiet while reset is held.
    assign dmem_req_valid = ~reset & (w_issue | (state_q == S_REQ));
    assign stall_o        = ~reset & (w_issue | (state_q == S_REQ) |
                                      ((state_q == S_WAIT) & ~dmem_rsp_valid));
    assign dmem_we        = dmem_req_valid & mem_w_en_i;
    assign dmem_addr      = {alu_out_i[ADDR_LEN-1:2], 2'b00};

    always_comb begin
        dmem_wdata = rs2_data_i;
        dmem_wstrb = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                dmem_wdata = {4{rs2_data_i[7:0]}};
                dmem_wstrb = 4'b0001 << alu_out_i[1:0];
            end
            2'b01: begin
                dmem_wdata = {2{rs2_data_i[15:0]}};
                dmem_wstrb = alu_out_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (alu_out_i[1:0])
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            2'b11:   w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_half = alu_out_i[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_i)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    assign w_pc_plus4 = pc_i + ADDR_LEN'(4);
    assign w_alu_wb   = (wbsel_i == 2'd2) ? WIDTH'(w_pc_plus4) : alu_out_i;

    always_comb begin
        valid_d    = 1'b0;
        wb_data_d  = wb_data_q;
        rd_addr_d  = rd_addr_q;
        rf_w_en_d  = 1'b0;
        misalign_d = 1'b0;
        if (state_q == S_IDLE && valid_i && !w_mem_op) begin
            valid_d   = 1'b1;
            wb_data_d = w_alu_wb;
            rd_addr_d = rd_addr_i;
            rf_w_en_d = rf_w_en_i;
        end else if (state_q == S_IDLE && w_mem_op && w_misaligned) begin
            valid_d    = 1'b1;
            rd_addr_d  = rd_addr_i;
            misalign_d = 1'b1;
        end else if (state_q == S_WAIT && dmem_rsp_valid) begin
            valid_d   = 1'b1;
            rd_addr_d = rd_addr_i;
            if (!mem_w_en_i) begin
                wb_data_d = w_load_data;
                rf_w_en_d = rf_w_en_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            wb_data_q  <= '0;
            rd_addr_q  <= '0;
            rf_w_en_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            wb_data_q  <= wb_data_d;
            rd_addr_q  <= rd_addr_d;
            rf_w_en_q  <= rf_w_en_d;
            misalign_q <= misalign_d;
        end
    end

    assign valid_o    = valid_q;
    assign wb_data_o  = wb_data_q;
    assign rd_addr_o  = rd_addr_q;
    assign rf_w_en_o  = rf_w_en_q;
    assign misalign_o = misalign_q;

endmodule
`default_nettype wire
